loadip_wr_ctrl: RTL and testbench
=================================

// Module: loadip_wr_ctrl
// PURPOSE
//  Write-side sequencer for the loadip ping-pong buffer. Takes an upstream valid/ready/last stream,
//  claims a free buffer half, streams beats as one contiguous strobe burst, then releases the half
//  so the read side sees it as ready. Selection alternates halves (ping-pong) and never splits a burst.
// PARAMETERS
//  DATA_WIDTH  16  data beat width; matches buffer DATA_WIDTH
//  ADDR_WIDTH  8   buffer half address width; DEPTH = 1<<ADDR_WIDTH beats max per block
// PORTS
//  i_clk           in   1           clock
//  i_rst_n         in   1           async reset, active low
//  i_s_valid       in   1           upstream beat valid
//  i_s_data        in   DATA_WIDTH  upstream beat data
//  i_s_last        in   1           upstream beat is last of block
//  o_s_ready       out  1           upstream beat accepted when valid&ready
//  i_wr_ready      in   2           buffer o_wr_ready, one bit per half
//  o_wr_activate   out  2           buffer i_wr_activate, one-hot or 0
//  o_wdata         out  DATA_WIDTH  buffer i_wdata
//  o_wstrobe       out  1           buffer i_wstrobe
//  o_busy          out  1           state != IDLE
//  o_blk_cnt       out  16          blocks committed (len>0), wraps 0xFFFF->0
//  o_last_len      out  ADDR_WIDTH+1 length of last committed block
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; next-half pointer r_next=0; beat counter 0.
//  FSM IDLE -> WRITE -> [FLUSH] -> RELEASE -> IDLE.
//  IDLE: o_s_ready=0. If i_s_valid && i_wr_ready!=0: pick half h = r_next if i_wr_ready[r_next],
//   else the other; r_next<=~h; o_wr_activate<=onehot(h) (registered); -> WRITE. Else stay.
//  WRITE: activate held; o_s_ready = 1 (combinational from state). Each accepted beat registers
//   o_wdata<=i_s_data, o_wstrobe<=1, cnt<=cnt+1 (latency 1 cycle accept->strobe).
//  Close conditions evaluated in WRITE at cycle N:
//   - accepted beat with i_s_last, or accepted beat making cnt==DEPTH -> FLUSH at N+1
//     (final strobe issued, activate high, s_ready 0), RELEASE at N+2.
//   - i_s_valid=0 (bubble, incl. first WRITE cycle) -> RELEASE at N+1 with o_wstrobe=0 and
//     o_wr_activate=0 in the same cycle. Required: buffer resets its address when strobe drops,
//     so strobes within one activation are strictly contiguous.
//   - last and full in the same beat: single close, FLUSH path.
//  RELEASE: activate=0, strobe=0, s_ready=0 for exactly 1 cycle; if cnt>0: o_blk_cnt+=1,
//   o_last_len<=cnt; cnt<=0; -> IDLE. Zero-length activation commits nothing.
//  Minimum gap between blocks: activate low >=1 cycle (RELEASE) before the next claim.
//  A half is never reclaimed until its i_wr_ready bit returns to 1; both 0 -> wait in IDLE.
//  cnt width ADDR_WIDTH+1; never exceeds DEPTH since s_ready deasserts after the DEPTH-th beat.
//  i_wr_ready changing during WRITE is ignored (the buffer clears it on strobe).
//  Async reset mid-block: outputs and state to reset values immediately; partial block dropped
//   (buffer is reset on the same i_rst_n), no block counted.
// TESTING
//  1 Assert i_rst_n=0 with random inputs -> all outputs 0; release, i_s_valid=0 -> stays IDLE, o_busy=0.
//  2 DEPTH=256, i_wr_ready=11, 300 back-to-back beats -> activate=01, 256 contiguous strobes,
//    s_ready low after beat 256, activate drops 2 cycles after it; blk_cnt=1, last_len=256;
//    remaining 44 beats go to half 1 (activate=10).
//  3 10 beats with i_s_last on beat 10 -> last_len=10, FLUSH seen, next block on other half.
//  4 i_s_valid drops after 5 beats -> strobe and activate fall same cycle, last_len=5;
//    resumed stream claims the other half and restarts at data beat 6.
//  5 i_wr_ready=00 with valid high -> s_ready 0, IDLE held; then i_wr_ready=10 with r_next=0
//    -> half 1 claimed, r_next becomes 0.
//  6 Async reset at beat 7 of a block -> activate/strobe/s_ready 0 same cycle, blk_cnt unchanged
//    (0), first block after reset claims half 0.

Source files
------------

// File: rtl/loadip_wr_ctrl.sv
// loadip_wr_ctrl: write-side sequencer for the loadip ping-pong buffer.
// Claims a free half, streams one contiguous strobe burst, then releases it.
module loadip_wr_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_s_valid,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic                  i_s_last,
    output logic                  o_s_ready,
    input  logic [1:0]            i_wr_ready,
    output logic [1:0]            o_wr_activate,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wstrobe,
    output logic                  o_busy,
    output logic [15:0]           o_blk_cnt,
    output logic [ADDR_WIDTH:0]   o_last_len
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FLUSH,
        S_RELEASE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_act;
    logic [1:0]            w_act_nxt;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] w_wdata_nxt;
    logic                  r_wstrobe;
    logic                  w_wstrobe_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW-1:0]         w_cnt_inc;
    logic                  r_next;
    logic                  w_next_nxt;
    logic                  w_h;
    logic [15:0]           r_blk_cnt;
    logic [15:0]           w_blk_cnt_nxt;
    logic [CW-1:0]         r_last_len;
    logic [CW-1:0]         w_last_len_nxt;

    // Next-state and next register values for the claim/stream/release sequence
    always_comb begin
        w_state_nxt    = r_state;
        w_act_nxt      = r_act;
        w_wdata_nxt    = r_wdata;
        w_wstrobe_nxt  = 1'b0;
        w_cnt_nxt      = r_cnt;
        w_next_nxt     = r_next;
        w_blk_cnt_nxt  = r_blk_cnt;
        w_last_len_nxt = r_last_len;
        w_cnt_inc      = r_cnt + CW'(1);
        // Prefer the pointed-to half; fall back to the other if it is busy.
        w_h            = i_wr_ready[r_next] ? r_next : ~r_next;
        unique case (r_state)
            S_IDLE: begin
                if (i_s_valid && (i_wr_ready != 2'b00)) begin
                    w_act_nxt   = w_h ? 2'b10 : 2'b01;
                    w_next_nxt  = ~w_h;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_s_valid) begin
                    w_wdata_nxt   = i_s_data;
                    w_wstrobe_nxt = 1'b1;
                    w_cnt_nxt     = w_cnt_inc;
                    if (i_s_last || (w_cnt_inc == DEPTH)) begin
                        w_state_nxt = S_FLUSH;
                    end
                end else begin
                    // Strobe and activate drop together so the buffer
                    // never sees a gap inside one activation.
                    w_act_nxt   = 2'b00;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_FLUSH: begin
                w_act_nxt   = 2'b00;
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (r_cnt != '0) begin
                    w_blk_cnt_nxt  = r_blk_cnt + 16'd1;
                    w_last_len_nxt = r_cnt;
                end
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, beat counter and ping-pong pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act      <= 2'b00;
            r_wdata    <= '0;
            r_wstrobe  <= 1'b0;
            r_cnt      <= '0;
            r_next     <= 1'b0;
            r_blk_cnt  <= 16'd0;
            r_last_len <= '0;
        end else begin
            r_act      <= w_act_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrobe  <= w_wstrobe_nxt;
            r_cnt      <= w_cnt_nxt;
            r_next     <= w_next_nxt;
            r_blk_cnt  <= w_blk_cnt_nxt;
            r_last_len <= w_last_len_nxt;
        end
    end

    assign o_s_ready     = (r_state == S_WRITE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_wr_activate = r_act;
    assign o_wdata       = r_wdata;
    assign o_wstrobe     = r_wstrobe;
    assign o_blk_cnt     = r_blk_cnt;
    assign o_last_len    = r_last_len;

endmodule

// File: tb/tb_loadip_wr_ctrl.sv
// tb_loadip_wr_ctrl: directed bench for loadip_wr_ctrl.
// Accepted beats go to a scoreboard and are matched against strobes.
module tb_loadip_wr_ctrl;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic [1:0]  wr_ready;
    logic [1:0]  wr_act;
    logic [15:0] wdata;
    logic        wstrobe;
    logic        busy;
    logic [15:0] blk_cnt;
    logic [8:0]  last_len;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  act;
    } sb_t;

    sb_t        sb[$];
    logic [1:0] exp_act;
    int         checks;
    int         errors;

    loadip_wr_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_s_valid     (s_valid),
        .i_s_data      (s_data),
        .i_s_last      (s_last),
        .o_s_ready     (s_ready),
        .i_wr_ready    (wr_ready),
        .o_wr_activate (wr_act),
        .o_wdata       (wdata),
        .o_wstrobe     (wstrobe),
        .o_busy        (busy),
        .o_blk_cnt     (blk_cnt),
        .o_last_len    (last_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every strobe must match the oldest accepted beat and its half.
    always @(negedge clk) begin
        if (wstrobe === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", {31'd0, wstrobe}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_data", {16'd0, wdata}, {16'd0, e.data});
                chk("sb_act", {30'd0, wr_act}, {30'd0, e.act});
            end
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic l);
        int   n;
        sb_t  e;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!s_ready && n < 64);
        if (!s_ready) begin
            chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        end else begin
            e.data = d;
            e.act  = exp_act;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_commit(input string tag, input int bc, input int ll);
        chk({tag, "_blk"}, {16'd0, blk_cnt}, bc);
        chk({tag, "_len"}, {23'd0, last_len}, ll);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        exp_act  = 2'b01;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 16'd0;
        s_last   = 1'b0;
        wr_ready = 2'b11;

        // 1: reset with random inputs, then idle
        for (int i = 0; i < 5; i++) begin
            s_valid  = 1'($urandom);
            s_data   = 16'($urandom);
            s_last   = 1'($urandom);
            wr_ready = 2'($urandom);
            @(negedge clk);
            chk("rst_act", {30'd0, wr_act}, 0);
            chk("rst_strobe", {31'd0, wstrobe}, 0);
            chk("rst_ready", {31'd0, s_ready}, 0);
            chk("rst_busy", {31'd0, busy}, 0);
        end
        chk("rst_wdata", {16'd0, wdata}, 0);
        chk_commit("rst", 0, 0);
        s_valid  = 1'b0;
        s_last   = 1'b0;
        wr_ready = 2'b11;
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_act", {30'd0, wr_act}, 0);

        // 2: 300 back-to-back beats, full block then remainder
        exp_act = 2'b01;
        for (int i = 1; i <= 300; i++) begin
            if (i == 257) exp_act = 2'b10;
            send_beat(16'(i), 1'b0);
            if (i == 256) begin
                s_data = 16'd257;
                @(negedge clk);
                chk("full_flush_ready", {31'd0, s_ready}, 0);
                chk("full_flush_strobe", {31'd0, wstrobe}, 1);
                chk("full_flush_act", {30'd0, wr_act}, 32'd1);
                @(negedge clk);
                chk("full_rel_act", {30'd0, wr_act}, 0);
                chk("full_rel_strobe", {31'd0, wstrobe}, 0);
                @(negedge clk);
                chk_commit("full", 1, 256);
            end
        end
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_commit("rest", 2, 44);

        // 3: 10-beat block closed by last
        exp_act = 2'b01;
        for (int i = 1; i <= 10; i++) send_beat(16'h1000 + 16'(i), i == 10);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        chk("last_flush_busy", {31'd0, busy}, 1);
        chk("last_flush_ready", {31'd0, s_ready}, 0);
        chk("last_flush_strobe", {31'd0, wstrobe}, 1);
        repeat (2) @(negedge clk);
        chk_commit("last", 3, 10);

        // 4: bubble after 5 beats, resume on other half
        exp_act = 2'b10;
        for (int i = 1; i <= 5; i++) send_beat(16'h2000 + 16'(i), 1'b0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("bub_strobe", {31'd0, wstrobe}, 1);
        chk("bub_act", {30'd0, wr_act}, 32'd2);
        @(negedge clk);
        chk("bub_drop_strobe", {31'd0, wstrobe}, 0);
        chk("bub_drop_act", {30'd0, wr_act}, 0);
        @(negedge clk);
        chk_commit("bub", 4, 5);
        exp_act = 2'b01;
        for (int i = 6; i <= 8; i++) send_beat(16'h2000 + 16'(i), i == 8);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk_commit("resume", 5, 3);

        // 5: no free half, then only half 1 free
        exp_act = 2'b10;
        send_beat(16'h3001, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk_commit("prep", 6, 1);
        wr_ready = 2'b00;
        s_valid  = 1'b1;
        s_data   = 16'h3101;
        repeat (4) @(negedge clk);
        chk("nofree_ready", {31'd0, s_ready}, 0);
        chk("nofree_busy", {31'd0, busy}, 0);
        chk("nofree_act", {30'd0, wr_act}, 0);
        wr_ready = 2'b10;
        exp_act  = 2'b10;
        send_beat(16'h3101, 1'b0);
        send_beat(16'h3102, 1'b1);
        s_valid  = 1'b0;
        s_last   = 1'b0;
        wr_ready = 2'b11;
        repeat (3) @(negedge clk);
        chk_commit("half1", 7, 2);
        exp_act = 2'b01;
        send_beat(16'h3201, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk_commit("half0", 8, 1);

        // zero-length activation commits nothing
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        @(negedge clk);
        chk("zero_busy", {31'd0, busy}, 1);
        chk("zero_act", {30'd0, wr_act}, 32'd2);
        chk("zero_strobe", {31'd0, wstrobe}, 0);
        @(negedge clk);
        chk("zero_rel_act", {30'd0, wr_act}, 0);
        @(negedge clk);
        chk_commit("zero", 8, 1);

        // 6: async reset at beat 7
        exp_act = 2'b01;
        for (int i = 1; i <= 6; i++) send_beat(16'h4000 + 16'(i), 1'b0);
        s_data = 16'h4007;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_act", {30'd0, wr_act}, 0);
        chk("arst_strobe", {31'd0, wstrobe}, 0);
        chk("arst_ready", {31'd0, s_ready}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_blk", {16'd0, blk_cnt}, 0);
        sb.delete();
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_act = 2'b01;
        for (int i = 1; i <= 3; i++) send_beat(16'h5000 + 16'(i), i == 3);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk_commit("post_rst", 1, 3);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
